// File: rtl/gate_sweep_sequencer.sv
// Self-test sequencer for the three-input gate block: sweeps all eight input
// vectors, samples {d,j,f,k} after a settle delay and compares to a golden table.
module gate_sweep_sequencer #(
  parameter int          SETTLE   = 2,
  parameter logic [31:0] EXPECTED = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        a,
  output logic        b,
  output logic        c,
  input  logic        d,
  input  logic        j,
  input  logic        f,
  input  logic        k,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  err_count,
  output logic [31:0] result,
  output logic [2:0]  vec_idx
);

  localparam int          SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam logic [15:0] CNT_RELOAD = 16'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  vec_q, vec_d;
  logic [2:0]  abc_q, abc_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [3:0]  err_q, err_d;
  logic [31:0] result_q, result_d;

  logic [3:0] sample_nib;
  logic [3:0] expect_nib;
  logic       mismatch;
  logic [3:0] err_next;
  logic       sample_edge;

  assign sample_nib  = {d, j, f, k};
  assign expect_nib  = EXPECTED[{vec_q, 2'b00} +: 4];
  assign mismatch    = (sample_nib != expect_nib);
  assign err_next    = err_q + {3'b000, mismatch};
  // abort outranks a coinciding sample edge
  assign sample_edge = (state_q == RUN) && !abort && (cnt_q == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 16'd0;
      vec_q    <= 3'd0;
      abc_q    <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 4'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vec_q    <= vec_d;
      abc_q    <= abc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (abort)                           state_d = IDLE;
        else if (sample_edge && vec_q == 3'd7) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    vec_d    = vec_q;
    abc_d    = abc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          vec_d    = 3'd0;
          abc_d    = 3'd0;
          cnt_d    = CNT_RELOAD;
          result_d = 32'd0;
          err_d    = 4'd0;
          pass_d   = 1'b0;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          busy_d = 1'b0;
          abc_d  = 3'd0;
          pass_d = 1'b0;
        end else if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          result_d[{vec_q, 2'b00} +: 4] = sample_nib;
          err_d = err_next;
          if (vec_q == 3'd7) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            abc_d  = 3'd0;
            pass_d = (err_next == 4'd0);
          end else begin
            vec_d = vec_q + 3'd1;
            abc_d = vec_q + 3'd1;
            cnt_d = CNT_RELOAD;
          end
        end
      end
      default: ;
    endcase
  end

  assign {a, b, c}  = abc_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign result     = result_q;
  assign vec_idx    = vec_q;

endmodule

// File: tb/tb_gate_sweep_sequencer.sv
// Bench for gate_sweep_sequencer: four instances (different SETTLE/EXPECTED and
// gate behaviours) share one stimulus stream and are checked against a sweep model.
module tb_gate_sweep_sequencer;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic modeA = 1'b0;

  logic        aW [4];
  logic        bW [4];
  logic        cW [4];
  logic        dW [4];
  logic        jW [4];
  logic        fW [4];
  logic        kW [4];
  logic        busyW [4];
  logic        doneW [4];
  logic        passW [4];
  logic [3:0]  errW [4];
  logic [31:0] resW [4];
  logic [2:0]  vecW [4];

  int vectors     = 0;
  int miscompares = 0;
  int doneCnt [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  // u0: tied gate (all 0 or all 1); u1..u3: loopback {d,j,f,k} = {a,b,c,a}
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int          S = (g == 1 || g == 2) ? 3 : 2;
    localparam logic [31:0] E = (g == 0) ? 32'h0000_0000 :
                                (g == 2) ? 32'hFDB9_6421 : 32'hFDB9_6420;
    if (g == 0) begin : g_tie
      assign {dW[g], jW[g], fW[g], kW[g]} = {4{modeA}};
    end else begin : g_loop
      assign {dW[g], jW[g], fW[g], kW[g]} = {aW[g], bW[g], cW[g], aW[g]};
    end
    gate_sweep_sequencer #(.SETTLE(S), .EXPECTED(E)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .a(aW[g]), .b(bW[g]), .c(cW[g]),
      .d(dW[g]), .j(jW[g]), .f(fW[g]), .k(kW[g]),
      .busy(busyW[g]), .done(doneW[g]), .pass(passW[g]),
      .err_count(errW[g]), .result(resW[g]), .vec_idx(vecW[g])
    );
  end

  function automatic int settleOf(input int i);
    return (i == 1 || i == 2) ? 3 : 2;
  endfunction

  function automatic logic [31:0] expectOf(input int i);
    case (i)
      0:       return 32'h0000_0000;
      2:       return 32'hFDB9_6421;
      default: return 32'hFDB9_6420;
    endcase
  endfunction

  function automatic logic [3:0] gateNibble(input int i, input int v);
    logic [2:0] vb;
    vb = 3'(v);
    if (i == 0) return {4{modeA}};
    return {vb[2], vb[1], vb[0], vb[2]};
  endfunction

  // Model: elapsed cycles since the accepted start decide when each vector is sampled
  bit          mRun  [4];
  bit          mDone [4];
  bit          mPass [4];
  int          mK    [4];
  int          mVec  [4];
  int          mErr  [4];
  logic [31:0] mRes  [4];

  task automatic modelStep(input int i);
    bit         wasDone;
    int         v;
    logic [3:0] nib;
    logic [31:0] ex;
    if (rst) begin
      mRun[i] = 0; mDone[i] = 0; mPass[i] = 0; mK[i] = 0;
      mVec[i] = 0; mErr[i] = 0; mRes[i] = 32'h0;
    end else if (!mRun[i]) begin
      wasDone  = mDone[i];
      mDone[i] = 0;
      if (start && !wasDone) begin
        mRun[i] = 1; mK[i] = 0; mVec[i] = 0; mErr[i] = 0;
        mPass[i] = 0; mRes[i] = 32'h0;
      end
    end else if (abort) begin
      mRun[i]  = 0;
      mPass[i] = 0;
    end else begin
      mK[i]++;
      if (mK[i] % settleOf(i) == 0) begin
        v   = mK[i] / settleOf(i) - 1;
        nib = gateNibble(i, v);
        ex  = expectOf(i);
        mRes[i][4*v +: 4] = nib;
        if (nib != ex[4*v +: 4]) mErr[i]++;
        if (v == 7) begin
          mRun[i]  = 0;
          mDone[i] = 1;
          mPass[i] = (mErr[i] == 0);
        end else begin
          mVec[i] = v + 1;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mRun[i] = 0; mDone[i] = 0; mPass[i] = 0; mK[i] = 0;
      mVec[i] = 0; mErr[i] = 0; mRes[i] = 32'h0;
    end
    forever begin
      @(posedge clk or posedge rst);
      for (int i = 0; i < 4; i++) modelStep(i);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("u%0d.busy", i),   32'(busyW[i]), 32'(mRun[i]));
      checkOutput($sformatf("u%0d.done", i),   32'(doneW[i]), 32'(mDone[i]));
      checkOutput($sformatf("u%0d.pass", i),   32'(passW[i]), 32'(mPass[i]));
      checkOutput($sformatf("u%0d.err", i),    32'(errW[i]),  32'(mErr[i]));
      checkOutput($sformatf("u%0d.result", i), resW[i],       mRes[i]);
      checkOutput($sformatf("u%0d.vec", i),    32'(vecW[i]),  32'(mVec[i]));
      checkOutput($sformatf("u%0d.abc", i),    32'({aW[i], bW[i], cW[i]}),
                  mRun[i] ? 32'(mVec[i]) : 32'h0);
      if (doneW[i]) doneCnt[i]++;
    end
  end

  task automatic applyStimulus(input logic s, input logic ab, input int cycles);
    start = s;
    abort = ab;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (cycles - 1) @(negedge clk);
  endtask

  task automatic clearDoneCounts();
    for (int i = 0; i < 4; i++) doneCnt[i] = 0;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Clean sweeps; extra starts while busy and during DONE must be ignored
    clearDoneCounts();
    applyStimulus(1'b1, 1'b0, 5);
    applyStimulus(1'b1, 1'b0, 12);
    applyStimulus(1'b1, 1'b0, 10);
    checkOutput("p1.u0.result", resW[0], 32'h0000_0000);
    checkOutput("p1.u0.pass",   32'(passW[0]), 32'd1);
    checkOutput("p1.u0.err",    32'(errW[0]),  32'd0);
    checkOutput("p1.u0.dones",  32'(doneCnt[0]), 32'd1);
    checkOutput("p1.u1.result", resW[1], 32'hFDB9_6420);
    checkOutput("p1.u1.pass",   32'(passW[1]), 32'd1);
    checkOutput("p1.u1.dones",  32'(doneCnt[1]), 32'd1);
    checkOutput("p1.u1.vec",    32'(vecW[1]),  32'd7);
    checkOutput("p1.u2.result", resW[2], 32'hFDB9_6420);
    checkOutput("p1.u2.err",    32'(errW[2]),  32'd1);
    checkOutput("p1.u2.pass",   32'(passW[2]), 32'd0);

    // Gate stuck at all-ones: every vector mismatches
    modeA = 1'b1;
    clearDoneCounts();
    applyStimulus(1'b1, 1'b0, 26);
    checkOutput("p2.u0.result", resW[0], 32'hFFFF_FFFF);
    checkOutput("p2.u0.err",    32'(errW[0]),  32'd8);
    checkOutput("p2.u0.pass",   32'(passW[0]), 32'd0);
    checkOutput("p2.u0.dones",  32'(doneCnt[0]), 32'd1);

    // Abort on the vec 3 sample edge of the SETTLE=2 loopback instance
    modeA = 1'b0;
    clearDoneCounts();
    applyStimulus(1'b1, 1'b0, 8);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("p3.u3.busy",   32'(busyW[3]), 32'd0);
    checkOutput("p3.u3.abc",    32'({aW[3], bW[3], cW[3]}), 32'd0);
    checkOutput("p3.u3.result", resW[3], 32'h0000_0420);
    checkOutput("p3.u3.err",    32'(errW[3]),  32'd0);
    checkOutput("p3.u3.pass",   32'(passW[3]), 32'd0);
    applyStimulus(1'b0, 1'b0, 4);
    checkOutput("p3.u3.nodone", 32'(doneCnt[3]), 32'd0);
    applyStimulus(1'b1, 1'b0, 26);
    checkOutput("p3.u3.rerun.result", resW[3], 32'hFDB9_6420);
    checkOutput("p3.u3.rerun.pass",   32'(passW[3]), 32'd1);
    checkOutput("p3.u3.rerun.dones",  32'(doneCnt[3]), 32'd1);

    // Asynchronous reset between edges while u0 is on vector 5
    applyStimulus(1'b1, 1'b0, 11);
    checkOutput("p4.u0.vec_before", 32'(vecW[0]), 32'd5);
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("p4.u%0d.rst_outs", i),
                  {busyW[i], doneW[i], passW[i], aW[i], bW[i], cW[i], vecW[i], errW[i]}, 32'h0);
      checkOutput($sformatf("p4.u%0d.rst_result", i), resW[i], 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    clearDoneCounts();
    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("p4.u0.nodone", 32'(doneCnt[0]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gate_sweep_sequencer.md
Name: gate_sweep_sequencer

Overview:
Self-test sequencer for the three-input gate block (inputs a, b, c; outputs d, j, f, k). It sweeps all 8 input combinations in order and waits a programmable settle time per vector. It then samples the four gate outputs into a 32-bit result word and compares them against a golden truth table. It sits between a test/control master (start/abort handshake) and one gate-block instance, and reports pass/fail plus an error count.

Parameters:
SETTLE, 2, cycles each vector is driven before sampling; values below 1 behave as 1
EXPECTED, 32'h0000_0000, golden table; nibble [4*v+3:4*v] = {d,j,f,k} expected for vector v = {a,b,c}

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  begin sweep; honoured only in IDLE
abort  in  1  cancel sweep; honoured only while busy
a  out  1  gate input, = vec[2]
b  out  1  gate input, = vec[1]
c  out  1  gate input, = vec[0]
d  in  1  gate output
j  in  1  gate output
f  in  1  gate output
k  in  1  gate output
busy  out  1  sweep in progress
done  out  1  one-cycle pulse on sweep completion
pass  out  1  last completed sweep had zero mismatches
err_count  out  4  mismatching vectors in current/last sweep, 0..8
result  out  32  captured {d,j,f,k} per vector, same packing as EXPECTED
vec_idx  out  3  current vector index

Behaviour:
- Reset is asynchronous and active-high. The clock is clk and the reset is rst. Reset forces state=IDLE and clears every output and internal register (a/b/c=0, busy=0, done=0, pass=0, err_count=0, result=0, vec_idx=0, settle counter=0). Reset mid-sweep aborts immediately, with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE: a/b/c held 0. When start=1 at an edge:
  - vec_idx=0, cnt=SETTLE-1, result=0, err_count=0, pass=0, busy=1.
  - Next state is RUN.
- RUN: a/b/c = vec_idx bits, driven from registers (glitch-free).
  - At each edge with cnt!=0: cnt decrements.
  - At the edge with cnt==0 (the sample edge):
    - result[4*vec_idx +: 4] <= {d,j,f,k}.
    - If {d,j,f,k} != EXPECTED nibble, err_count increments.
    - If vec_idx==7: go to DONE with busy=0, done=1, and pass=1 iff the final err_count, including this vector's compare, is 0.
    - Otherwise: vec_idx increments and cnt=SETTLE-1.
- Timing: if start is taken at edge E0, sample edges are E0+SETTLE*(v+1) for v=0..7. busy=1 from E0 through E0+8*SETTLE. done=1 for exactly the cycle after edge E0+8*SETTLE.
- DONE: lasts one cycle; done is deasserted at the next edge and state returns to IDLE. start in DONE is ignored.
- After completion: pass, err_count, result and vec_idx (=7) hold until the next accepted start.
- abort=1 in RUN at any edge, including a sample edge:
  - abort wins; that edge performs no sample.
  - Next state is IDLE with busy=0, a/b/c=0, pass=0, done=0.
  - result and err_count keep their partial values.
  - abort in IDLE or DONE has no effect.
- start while busy is ignored. start and abort both high in IDLE: start is taken.
- err_count never exceeds 8, so no wrap occurs.
- Gate outputs are sampled only on sample edges. Values between sample edges do not matter.

Test Plan:
1. SETTLE=2, EXPECTED=0, d/j/f/k tied 0; pulse start -> busy high 16 cycles, done one-cycle pulse right after, pass=1, err_count=0, result=32'h0.
2. SETTLE=2, EXPECTED=0, d/j/f/k tied 1 -> err_count=8, pass=0, result=32'hFFFF_FFFF, single done pulse.
3. SETTLE=3, EXPECTED=32'hFDB9_6420, outputs looped back as {d,j,f,k}={a,b,c,a} -> samples at E3,E6,...,E24; result=32'hFDB9_6420; pass=1; err_count=0; done high only in the cycle after E24; a/b/c stepping 000..111 every 3 cycles.
4. Same as 3 with EXPECTED=32'hFDB9_6421 -> err_count=1, pass=0, result=32'hFDB9_6420.
5. Abort: SETTLE=2, loopback; abort asserted at the vec_idx=3 sample edge -> no sample at that edge, busy=0 next cycle, no done, a/b/c=000, result=32'h0000_0420, err_count=0, pass=0. A subsequent start runs a full clean sweep.
6. Reset and ignored inputs: assert rst asynchronously mid-sweep (vec_idx=5, between edges) -> all outputs 0 immediately, without waiting for clk. start pulses while busy and during DONE are ignored (exactly one done per accepted start).
